calc_seq_ctrl: RTL

Command sequencer for the calculator arithmetic datapath. Accepts keypad commands through a valid/ready handshake and builds decimal operands digit by digit. Dispatches add/sub/mult jobs to the multi-cycle arithmetic unit over a start/done handshake, range-checks results and drives calculator status and the value shown on the display scanner.

---
 rtl/calc_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keypad command sequencer for the calculator datapath.
// Builds decimal operands digit by digit, dispatches add/sub/mult jobs to the
// multi-cycle arithmetic unit and drives calculator status and display value.
module calc_seq_ctrl #(
    parameter int unsigned W          = 27,
    parameter int unsigned MAX_DIGITS = 8,
    parameter int unsigned LIMIT      = 99999999
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [3:0]     cmd,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    output logic [1:0]     status,
    output logic [W-1:0]   disp_value,
    output logic           alu_start,
    output logic [1:0]     alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic           alu_done,
    input  logic [2*W-1:0] alu_result
);

    localparam int unsigned    CW        = $clog2(MAX_DIGITS + 1);
    localparam logic [W+3:0]   LIMIT_ACC = (W+4)'(LIMIT);
    localparam logic [2*W-1:0] LIMIT_RES = (2*W)'(LIMIT);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(MAX_DIGITS);

    localparam logic [3:0] CMD_ADD   = 4'hA;
    localparam logic [3:0] CMD_SUB   = 4'hB;
    localparam logic [3:0] CMD_MULT  = 4'hC;
    localparam logic [3:0] CMD_EQUAL = 4'hE;
    localparam logic [3:0] CMD_CLEAR = 4'hF;

    localparam logic [1:0] STAT_ERRO    = 2'b00;
    localparam logic [1:0] STAT_PRONTA  = 2'b01;
    localparam logic [1:0] STAT_OCUPADA = 2'b10;

    typedef enum logic [2:0] {
        ST_ENTRY_A, ST_ENTRY_B, ST_ISSUE, ST_WAIT, ST_DRAIN, ST_ERROR
    } state_t;

    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MULT = 2'b10} op_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    op_t             op_q, op_d, pend_op_q, pend_op_d;
    logic            pend_eq_q, pend_eq_d;
    logic            result_mode_q, result_mode_d;
    logic            alu_start_q, alu_start_d;
    op_t             alu_op_q, alu_op_d;
    logic [W-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic [1:0]      status_q, status_d;
    logic [W-1:0]    disp_q, disp_d;

    logic            accept, is_digit, in_a, do_clear, issue_req, issue_eq;
    op_t             cmd_op, issue_op;
    logic [W-1:0]    x_cur;
    logic [CW-1:0]   cnt_cur;
    logic [W+3:0]    acc;

    // Next-state, operand registers and registered output values.
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_a_d       = cnt_a_q;
        cnt_b_d       = cnt_b_q;
        op_d          = op_q;
        pend_op_d     = pend_op_q;
        pend_eq_d     = pend_eq_q;
        result_mode_d = result_mode_q;
        alu_start_d   = 1'b0;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        do_clear      = 1'b0;
        issue_req     = 1'b0;
        issue_eq      = 1'b0;
        issue_op      = op_q;

        // Clear is the only command taken while the unit is busy.
        accept   = cmd_valid && (cmd_ready_q || cmd == CMD_CLEAR);
        is_digit = (cmd <= 4'd9);
        in_a     = (state_q == ST_ENTRY_A);

        // A displayed result is discarded by the first digit of a new entry.
        x_cur   = in_a ? (result_mode_q ? '0 : a_q) : b_q;
        cnt_cur = in_a ? (result_mode_q ? '0 : cnt_a_q) : cnt_b_q;
        acc     = {4'b0000, x_cur} * (W+4)'(10) + (W+4)'(cmd);

        case (cmd)
            CMD_SUB:  cmd_op = OP_SUB;
            CMD_MULT: cmd_op = OP_MULT;
            default:  cmd_op = OP_ADD;
        endcase

        case (state_q)
            ST_ENTRY_A, ST_ENTRY_B: begin
                if (accept) begin
                    if (cmd == CMD_CLEAR) begin
                        do_clear = 1'b1;
                    end else if (is_digit) begin
                        if (x_cur == '0 && cmd == 4'd0) begin
                            if (in_a) begin
                                a_d           = '0;
                                cnt_a_d       = '0;
                                result_mode_d = 1'b0;
                            end
                        end else if (cnt_cur == CNT_MAX || acc > LIMIT_ACC) begin
                            state_d = ST_ERROR;
                        end else if (in_a) begin
                            a_d           = acc[W-1:0];
                            cnt_a_d       = cnt_cur + CW'(1);
                            result_mode_d = 1'b0;
                        end else begin
                            b_d     = acc[W-1:0];
                            cnt_b_d = cnt_cur + CW'(1);
                        end
                    end else if (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_MULT) begin
                        if (in_a) begin
                            op_d    = cmd_op;
                            b_d     = '0;
                            cnt_b_d = '0;
                            state_d = ST_ENTRY_B;
                        end else if (cnt_b_q == '0) begin
                            op_d = cmd_op;
                        end else begin
                            issue_req = 1'b1;
                            issue_op  = cmd_op;
                        end
                    end else if (cmd == CMD_EQUAL && !in_a && cnt_b_q != '0) begin
                        issue_req = 1'b1;
                        issue_eq  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = (accept && cmd == CMD_CLEAR) ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (accept && cmd == CMD_CLEAR) begin
                    if (alu_done) do_clear = 1'b1;
                    else          state_d  = ST_DRAIN;
                end else if (alu_done) begin
                    if (alu_result > LIMIT_RES) begin
                        state_d = ST_ERROR;
                    end else begin
                        a_d           = alu_result[W-1:0];
                        cnt_a_d       = '0;
                        b_d           = '0;
                        cnt_b_d       = '0;
                        result_mode_d = 1'b1;
                        if (pend_eq_q) begin
                            state_d = ST_ENTRY_A;
                        end else begin
                            op_d    = pend_op_q;
                            state_d = ST_ENTRY_B;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (alu_done) do_clear = 1'b1;
            end
            ST_ERROR: begin
                if (accept && cmd == CMD_CLEAR) do_clear = 1'b1;
            end
            default: do_clear = 1'b1;
        endcase

        // Subtraction that would go negative is rejected before any job starts.
        if (issue_req) begin
            if (op_q == OP_SUB && a_q < b_q) begin
                state_d = ST_ERROR;
            end else begin
                state_d     = ST_ISSUE;
                alu_start_d = 1'b1;
                alu_a_d     = a_q;
                alu_b_d     = b_q;
                alu_op_d    = op_q;
                pend_eq_d   = issue_eq;
                pend_op_d   = issue_op;
            end
        end

        if (do_clear) begin
            state_d       = ST_ENTRY_A;
            a_d           = '0;
            b_d           = '0;
            cnt_a_d       = '0;
            cnt_b_d       = '0;
            op_d          = OP_ADD;
            pend_op_d     = OP_ADD;
            pend_eq_d     = 1'b0;
            result_mode_d = 1'b0;
            alu_start_d   = 1'b0;
            alu_op_d      = OP_ADD;
            alu_a_d       = '0;
            alu_b_d       = '0;
        end

        // Outputs are decoded from the next state so they leave a register.
        cmd_ready_d = 1'b0;
        status_d    = STAT_OCUPADA;
        disp_d      = '0;
        case (state_d)
            ST_ENTRY_A: begin
                cmd_ready_d = 1'b1;
                status_d    = STAT_PRONTA;
                disp_d      = a_d;
            end
            ST_ENTRY_B: begin
                cmd_ready_d = 1'b1;
                status_d    = STAT_PRONTA;
                disp_d      = (cnt_b_d != '0) ? b_d : a_d;
            end
            ST_ISSUE, ST_WAIT: disp_d = a_d;
            ST_ERROR: begin
                cmd_ready_d = 1'b1;
                status_d    = STAT_ERRO;
            end
            default: disp_d = '0;
        endcase
    end

    // Single state register for the sequencer; async active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_ENTRY_A;
            a_q           <= '0;
            b_q           <= '0;
            cnt_a_q       <= '0;
            cnt_b_q       <= '0;
            op_q          <= OP_ADD;
            pend_op_q     <= OP_ADD;
            pend_eq_q     <= 1'b0;
            result_mode_q <= 1'b0;
            alu_start_q   <= 1'b0;
            alu_op_q      <= OP_ADD;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            cmd_ready_q   <= 1'b1;
            status_q      <= STAT_PRONTA;
            disp_q        <= '0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_a_q       <= cnt_a_d;
            cnt_b_q       <= cnt_b_d;
            op_q          <= op_d;
            pend_op_q     <= pend_op_d;
            pend_eq_q     <= pend_eq_d;
            result_mode_q <= result_mode_d;
            alu_start_q   <= alu_start_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            cmd_ready_q   <= cmd_ready_d;
            status_q      <= status_d;
            disp_q        <= disp_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign status     = status_q;
    assign disp_value = disp_q;
    assign alu_start  = alu_start_q;
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;

endmodule
